// File: rtl/addsub_arbiter.sv
// addsub_arbiter
// Two requesters share one WIDTH-bit add/subtract datapath. A round-robin
// arbiter grants one request at a time. A three-state FSM captures the
// operands, computes the result and holds the response until it is accepted.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | arbitrate; winner's ready is high; capture on handshake
// EXEC  | compute the (WIDTH+1)-bit result from the captured operands
// RESP  | hold rsp_* stable until rsp_ready; count the completion
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   req0_valid/ready/x/y/s      requester 0 handshake, operands, op (1 = sub)
//   req1_valid/ready/x/y/s      requester 1 handshake, operands, op (1 = sub)
//   rsp_valid/ready             response handshake
//   rsp_id, rsp_result          owning requester, result (bit WIDTH = carry/borrow)
//   busy                        FSM not in IDLE
//   ops_done                    completed response handshakes (wraps)
module addsub_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_x,
  input  logic [WIDTH-1:0] req0_y,
  input  logic             req0_s,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_x,
  input  logic [WIDTH-1:0] req1_y,
  input  logic             req1_s,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH:0]   rsp_result,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] cap_x;
  logic [WIDTH-1:0] cap_y;
  logic             cap_s;
  logic             cap_id;

  logic             grant0;
  logic             grant1;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;

  // On a tie the requester that was not granted last time wins; the two
  // terms are mutually exclusive because last_grant picks exactly one.
  assign grant0 = (state == IDLE) && req0_valid && (!req1_valid || last_grant);
  assign grant1 = (state == IDLE) && req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state != IDLE);

  // Zero-extended operands: bit WIDTH of sum is the carry, of diff the borrow.
  assign sum  = {1'b0, cap_x} + {1'b0, cap_y};
  assign diff = {1'b0, cap_x} - {1'b0, cap_y};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cap_x      <= '0;
      cap_y      <= '0;
      cap_s      <= 1'b0;
      cap_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      ops_done   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            cap_x      <= grant1 ? req1_x : req0_x;
            cap_y      <= grant1 ? req1_y : req0_y;
            cap_s      <= grant1 ? req1_s : req0_s;
            cap_id     <= grant1;
            last_grant <= grant1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= cap_s ? diff : sum;
          rsp_id     <= cap_id;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            ops_done  <= ops_done + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed testbench for addsub_arbiter with hand-computed expected values.
module tb_addsub_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_x, req0_y, req1_x, req1_y;
  logic       req0_s, req1_s;
  logic       rsp_valid, rsp_ready, rsp_id;
  logic [4:0] rsp_result;
  logic       busy;
  logic [7:0] ops_done;

  int passed  = 0;
  int total   = 0;
  int exp_ops = 0;

  addsub_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_x     (req0_x),
    .req0_y     (req0_y),
    .req0_s     (req0_s),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_x     (req1_x),
    .req1_y     (req1_y),
    .req1_s     (req1_s),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // One complete operation from requester `id`, with the other requester idle.
  task automatic run_op(input logic id, input logic [3:0] x, input logic [3:0] y,
                        input logic s, input logic [4:0] expr);
    if (id) begin
      req1_valid = 1'b1; req1_x = x; req1_y = y; req1_s = s;
    end else begin
      req0_valid = 1'b1; req0_x = x; req0_y = y; req0_s = s;
    end
    #1;
    check("idle_ready0", 32'(req0_ready), 32'(!id));
    check("idle_ready1", 32'(req1_ready), 32'(id));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
    tick();
    check("resp_valid", 32'(rsp_valid), 32'd1);
    check("resp_id", 32'(rsp_id), 32'(id));
    check("resp_result", 32'(rsp_result), 32'(expr));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_ops++;
    check("done_valid", 32'(rsp_valid), 32'd0);
    check("done_busy", 32'(busy), 32'd0);
    check("done_count", 32'(ops_done), 32'(exp_ops));
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_x = '0; req0_y = '0; req0_s = 1'b0;
    req1_valid = 1'b0; req1_x = '0; req1_y = '0; req1_s = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ops_done", 32'(ops_done), 32'd0);
    check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);

    // 13 - 11 = 2
    run_op(1'b0, 4'b1101, 4'b1011, 1'b1, 5'b00010);
    // 10 + 6 = 16, carry set
    run_op(1'b1, 4'b1010, 4'b0110, 1'b0, 5'b10000);
    // 7 + 5 = 12
    run_op(1'b1, 4'b0111, 4'b0101, 1'b0, 5'b01100);
    // 5 - 7 = -2
    run_op(1'b0, 4'b0101, 4'b0111, 1'b1, 5'b11110);

    // Contention from reset: both valid continuously, grants alternate 0,1,0,1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_ops = 0;
    req0_valid = 1'b1; req0_x = 4'b0111; req0_y = 4'b0101; req0_s = 1'b0;
    req1_valid = 1'b1; req1_x = 4'b0111; req1_y = 4'b0101; req1_s = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_ready0", 32'(req0_ready), 32'(k % 2 == 0));
      check("rr_ready1", 32'(req1_ready), 32'(k % 2 == 1));
      tick();
      check("rr_exec_ready", 32'({req0_ready, req1_ready}), 32'd0);
      tick();
      check("rr_resp_ready", 32'({req0_ready, req1_ready}), 32'd0);
      check("rr_valid", 32'(rsp_valid), 32'd1);
      check("rr_id", 32'(rsp_id), 32'(k % 2));
      check("rr_result", 32'(rsp_result), (k % 2 == 0) ? 32'h0C : 32'h02);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      exp_ops++;
      check("rr_count", 32'(ops_done), 32'(exp_ops));
    end

    // Backpressure: req0 op held in RESP while req1 waits.
    req1_valid = 1'b0;
    req0_x = 4'b0011; req0_y = 4'b0001; req0_s = 1'b0;
    #1;
    check("bp_grant0", 32'(req0_ready), 32'd1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_x = 4'b1111; req1_y = 4'b0001; req1_s = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd0);
      check("bp_result", 32'(rsp_result), 32'h04);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_count", 32'(ops_done), 32'(exp_ops));
      check("bp_no_grant", 32'(req1_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    exp_ops++;
    check("bp_count_once", 32'(ops_done), 32'(exp_ops));
    check("bp_waiter_granted", 32'(req1_ready), 32'd1);
    tick();
    req1_valid = 1'b0;
    #1;
    check("mid_exec_busy", 32'(busy), 32'd1);

    // Reset during EXEC aborts the operation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(ops_done), 32'd0);
    tick();
    check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    check("abort_idle_count", 32'(ops_done), 32'd0);

    // Tie right after reset goes to requester 0.
    req0_valid = 1'b1; req0_x = 4'b1000; req0_y = 4'b1000; req0_s = 1'b0;
    req1_valid = 1'b1; req1_x = 4'b0001; req1_y = 4'b0001; req1_s = 1'b0;
    #1;
    check("tie_ready0", 32'(req0_ready), 32'd1);
    check("tie_ready1", 32'(req1_ready), 32'd0);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check("tie_id", 32'(rsp_id), 32'd0);
    check("tie_result", 32'(rsp_result), 32'h10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
